// File: rtl/flash_boot_loader.sv
// Purpose: boot sequencer; reads a 4-word image header from flash, copies N payload words to SRAM, then raises start.
// Latency: go to first fl_req is 1 cycle; header is 8 cycles, check 1, each payload word 4 cycles with zero-wait acks.
// Backpressure: req/ack on both ports; req holds with stable addr/data until ack, unbounded wait, >=1 idle cycle between reqs.
//
// Ports:
//   sys_clk, sys_rst          clock, synchronous active-low reset
//   go                        level boot trigger, only looked at in IDLE
//   fl_req/fl_addr/fl_ack/fl_rdata          flash word read port
//   sr_req/sr_addr/sr_wdata/sr_ack          SRAM word write port
//   busy, start, err, words_done            status (start and err are sticky until reset)
module flash_boot_loader #(
    parameter int FLASH_AW   = 25,
    parameter int SRAM_AW    = 22,
    parameter int HDR_BASE   = 0,
    parameter int FLASH_STEP = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                go,
    output logic                fl_req,
    output logic [FLASH_AW-1:0] fl_addr,
    input  logic                fl_ack,
    input  logic [31:0]         fl_rdata,
    output logic                sr_req,
    output logic [SRAM_AW-1:0]  sr_addr,
    output logic [31:0]         sr_wdata,
    input  logic                sr_ack,
    output logic                busy,
    output logic                start,
    output logic                err,
    output logic [31:0]         words_done
);

    typedef enum logic [2:0] {IDLE, HDR, CHK, RD, WR, DONE, ERR} state_t;

    // A count of exactly 2^SRAM_AW fills the whole SRAM and is still accepted.
    localparam logic [32:0] N_LIMIT = 33'd1 << SRAM_AW;

    state_t              state, state_nx;
    logic                fl_req_nx, sr_req_nx, busy_nx, start_nx, err_nx;
    logic [FLASH_AW-1:0] fl_addr_nx;
    logic [SRAM_AW-1:0]  sr_addr_nx;
    logic [31:0]         sr_wdata_nx, words_done_nx;
    logic [2:0]          hdr_cnt, hdr_cnt_nx;
    logic [SRAM_AW-1:0]  dest, dest_nx;
    logic [31:0]         n_words, n_words_nx;
    logic                rsv_bad, rsv_bad_nx;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state      <= IDLE;
            fl_req     <= 1'b0;
            fl_addr    <= '0;
            sr_req     <= 1'b0;
            sr_addr    <= '0;
            sr_wdata   <= '0;
            busy       <= 1'b0;
            start      <= 1'b0;
            err        <= 1'b0;
            words_done <= '0;
            hdr_cnt    <= '0;
            dest       <= '0;
            n_words    <= '0;
            rsv_bad    <= 1'b0;
        end else begin
            state      <= state_nx;
            fl_req     <= fl_req_nx;
            fl_addr    <= fl_addr_nx;
            sr_req     <= sr_req_nx;
            sr_addr    <= sr_addr_nx;
            sr_wdata   <= sr_wdata_nx;
            busy       <= busy_nx;
            start      <= start_nx;
            err        <= err_nx;
            words_done <= words_done_nx;
            hdr_cnt    <= hdr_cnt_nx;
            dest       <= dest_nx;
            n_words    <= n_words_nx;
            rsv_bad    <= rsv_bad_nx;
        end
    end

    // Every register is computed here as a next value so that req lines stay
    // registered. Inside HDR/RD/WR a low req means "idle cycle after the last
    // completion": that is where the next request is raised.
    always_comb begin
        state_nx      = state;
        fl_req_nx     = fl_req;
        fl_addr_nx    = fl_addr;
        sr_req_nx     = sr_req;
        sr_addr_nx    = sr_addr;
        sr_wdata_nx   = sr_wdata;
        busy_nx       = busy;
        start_nx      = start;
        err_nx        = err;
        words_done_nx = words_done;
        hdr_cnt_nx    = hdr_cnt;
        dest_nx       = dest;
        n_words_nx    = n_words;
        rsv_bad_nx    = rsv_bad;

        case (state)
            IDLE: begin
                if (go) begin
                    state_nx      = HDR;
                    fl_req_nx     = 1'b1;
                    fl_addr_nx    = FLASH_AW'(HDR_BASE);
                    busy_nx       = 1'b1;
                    hdr_cnt_nx    = '0;
                    rsv_bad_nx    = 1'b0;
                    words_done_nx = '0;
                end
            end

            HDR: begin
                if (fl_req) begin
                    if (fl_ack) begin
                        fl_req_nx  = 1'b0;
                        // fl_addr walks on through the header into the payload.
                        fl_addr_nx = fl_addr + FLASH_AW'(FLASH_STEP);
                        hdr_cnt_nx = hdr_cnt + 3'd1;
                        case (hdr_cnt)
                            3'd0:    dest_nx    = fl_rdata[SRAM_AW-1:0];
                            3'd1:    n_words_nx = fl_rdata;
                            default: if (fl_rdata != 32'd0) rsv_bad_nx = 1'b1;
                        endcase
                    end
                end else if (hdr_cnt == 3'd4) begin
                    state_nx = CHK;
                end else begin
                    fl_req_nx = 1'b1;
                end
            end

            CHK: begin
                sr_addr_nx = dest;
                if (rsv_bad || ({1'b0, n_words} > N_LIMIT)) begin
                    state_nx = ERR;
                    err_nx   = 1'b1;
                    busy_nx  = 1'b0;
                end else if (n_words == 32'd0) begin
                    state_nx = DONE;
                    start_nx = 1'b1;
                    busy_nx  = 1'b0;
                end else begin
                    state_nx = RD;
                end
            end

            RD: begin
                if (fl_req) begin
                    if (fl_ack) begin
                        fl_req_nx   = 1'b0;
                        fl_addr_nx  = fl_addr + FLASH_AW'(FLASH_STEP);
                        sr_wdata_nx = fl_rdata;
                        state_nx    = WR;
                    end
                end else begin
                    fl_req_nx = 1'b1;
                end
            end

            WR: begin
                if (sr_req) begin
                    if (sr_ack) begin
                        sr_req_nx     = 1'b0;
                        sr_addr_nx    = sr_addr + SRAM_AW'(1);  // wraps mod 2^SRAM_AW
                        words_done_nx = words_done + 32'd1;
                        if (words_done + 32'd1 == n_words) begin
                            state_nx = DONE;
                            start_nx = 1'b1;
                            busy_nx  = 1'b0;
                        end else begin
                            state_nx = RD;
                        end
                    end
                end else begin
                    sr_req_nx = 1'b1;
                end
            end

            default: ;  // DONE and ERR hold until reset
        endcase
    end

endmodule

// File: tb/tb_flash_boot_loader.sv
module tb_flash_boot_loader;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        go = 1'b0;
    logic        fl_req;
    logic [24:0] fl_addr;
    logic        fl_ack = 1'b0;
    logic [31:0] fl_rdata = 32'd0;
    logic        sr_req;
    logic [21:0] sr_addr;
    logic [31:0] sr_wdata;
    logic        sr_ack = 1'b0;
    logic        busy, start, err;
    logic [31:0] words_done;

    always #5 sys_clk = ~sys_clk;

    flash_boot_loader #(.FLASH_AW(25), .SRAM_AW(22), .HDR_BASE(0), .FLASH_STEP(1)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .go(go),
        .fl_req(fl_req), .fl_addr(fl_addr), .fl_ack(fl_ack), .fl_rdata(fl_rdata),
        .sr_req(sr_req), .sr_addr(sr_addr), .sr_wdata(sr_wdata), .sr_ack(sr_ack),
        .busy(busy), .start(start), .err(err), .words_done(words_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Flash image and payload used by the loads
    logic [31:0] fmem [0:15];
    logic [31:0] pay  [0:4] = '{32'h34090001, 32'h340A0002, 32'h340C0004, 32'h340D0005, 32'h014B4820};
    int rd_cnt [0:15];
    int rd_other = 0;
    int rd_total = 0;

    // Responder controls
    bit rnd = 1'b0;
    int hold_idx = -1;
    int wr_idx = 0;
    int wr_total = 0;
    bit late_ack = 1'b0;
    int start_rises = 0;

    logic [53:0] exp_q [$];

    task automatic set_image(input logic [31:0] d, input logic [31:0] n,
                             input logic [31:0] w2, input logic [31:0] w3, input int np);
        for (int i = 0; i < 16; i++) begin
            fmem[i] = 32'd0;
            rd_cnt[i] = 0;
        end
        fmem[0] = d; fmem[1] = n; fmem[2] = w2; fmem[3] = w3;
        for (int i = 0; i < np; i++) fmem[4+i] = pay[i];
        rd_other = 0;
        rd_total = 0;
    endtask

    task automatic push_exp(input logic [21:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic pulse_go();
        @(negedge sys_clk) go = 1'b1;
        @(negedge sys_clk) go = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge sys_clk) sys_rst = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk) sys_rst = 1'b1;
    endtask

    task automatic wait_end(input int bound);
        for (int i = 0; i < bound && !(start || err); i++) @(negedge sys_clk);
        chk("load_finished", {63'd0, start | err}, 64'd1);
    endtask

    // Flash responder plus protocol checks on the flash port
    initial begin
        bit f_wait = 1'b0, f_prev_req = 1'b0, f_prev_done = 1'b0;
        int f_cnt = 0;
        logic [24:0] f_prev_addr = '0;
        forever begin
            @(negedge sys_clk);
            if (f_prev_done) chk("fl_idle_gap", {63'd0, fl_req}, 64'd0);
            if (f_prev_req && fl_req && !f_prev_done) chk("fl_addr_stable", 64'(fl_addr), 64'(f_prev_addr));
            f_prev_done = 1'b0;
            if (fl_ack) begin
                fl_ack = 1'b0;
            end else if (fl_req) begin
                if (!f_wait) begin
                    f_wait = 1'b1;
                    f_cnt = rnd ? int'($urandom_range(0, 7)) : 0;
                end
                if (f_cnt == 0) begin
                    fl_ack = 1'b1;
                    f_wait = 1'b0;
                    f_prev_done = 1'b1;
                    rd_total++;
                    if (fl_addr < 25'd16) begin
                        fl_rdata = fmem[fl_addr[3:0]];
                        rd_cnt[fl_addr[3:0]]++;
                    end else begin
                        fl_rdata = 32'hDEADBEEF;
                        rd_other++;
                    end
                end else begin
                    f_cnt--;
                end
            end else begin
                f_wait = 1'b0;
            end
            f_prev_req = fl_req;
            f_prev_addr = fl_addr;
        end
    end

    // SRAM responder and scoreboard monitor
    initial begin
        bit s_wait = 1'b0, s_prev_req = 1'b0, s_prev_done = 1'b0;
        int s_cnt = 0;
        logic [53:0] s_prev = '0;
        logic [53:0] e;
        forever begin
            @(negedge sys_clk);
            if (s_prev_done) chk("sr_idle_gap", {63'd0, sr_req}, 64'd0);
            if (s_prev_req && sr_req && !s_prev_done) chk("sr_addr_data_stable", 64'({sr_addr, sr_wdata}), 64'(s_prev));
            s_prev_done = 1'b0;
            if (sr_ack) begin
                sr_ack = 1'b0;
            end else if (late_ack) begin
                sr_ack = 1'b1;
                late_ack = 1'b0;
            end else if (sr_req && wr_idx != hold_idx) begin
                if (!s_wait) begin
                    s_wait = 1'b1;
                    s_cnt = rnd ? int'($urandom_range(0, 7)) : 0;
                end
                if (s_cnt == 0) begin
                    sr_ack = 1'b1;
                    s_wait = 1'b0;
                    s_prev_done = 1'b1;
                    wr_idx++;
                    wr_total++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_sr_write", 64'({sr_addr, sr_wdata}), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sr_write", 64'({sr_addr, sr_wdata}), 64'(e));
                    end
                end else begin
                    s_cnt--;
                end
            end else if (!sr_req) begin
                s_wait = 1'b0;
            end
            s_prev_req = sr_req;
            s_prev = {sr_addr, sr_wdata};
        end
    end

    initial begin
        bit st_prev = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (start && !st_prev) start_rises++;
            st_prev = start;
        end
    end

    initial begin
        int rd_before;

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_reqs", {62'd0, fl_req, sr_req}, 64'd0);
        chk("rst_status", {61'd0, busy, start, err}, 64'd0);
        chk("rst_words_done", 64'(words_done), 64'd0);
        chk("rst_addr_data", 64'({fl_addr, sr_addr}), 64'd0);
        chk("rst_wdata", 64'(sr_wdata), 64'd0);
        sys_rst = 1'b1;

        // Nominal load with zero-wait acks and exact cycle timing
        set_image(32'hC00, 32'd5, 32'd0, 32'd0, 5);
        for (int i = 0; i < 5; i++) push_exp(22'hC00 + 22'(i), pay[i]);
        @(negedge sys_clk) go = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            @(negedge sys_clk);
            if (c == 1) begin
                go = 1'b0;
                chk("go_to_req", {62'd0, fl_req, busy}, 64'd3);
                chk("go_fl_addr", 64'(fl_addr), 64'd0);
            end
            if (c == 29) chk("nom_start_before", {63'd0, start}, 64'd0);
            if (c == 30) chk("nom_start_at", {63'd0, start}, 64'd1);
        end
        chk("nom_words_done", 64'(words_done), 64'd5);
        chk("nom_status", {61'd0, busy, start, err}, 64'b010);
        chk("nom_queue_empty", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 9; i++) chk("nom_flash_read_once", 64'(rd_cnt[i]), 64'd1);
        chk("nom_flash_no_extra", 64'(rd_total), 64'd9);

        // Zero count
        do_reset();
        set_image(32'h100, 32'd0, 32'd0, 32'd0, 0);
        wr_total = 0;
        @(negedge sys_clk) go = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge sys_clk);
            go = 1'b0;
            if (c == 9) chk("zero_chk_cycle", {62'd0, busy, start}, 64'b10);
            if (c == 10) chk("zero_start", {62'd0, busy, start}, 64'b01);
        end
        chk("zero_words_done", 64'(words_done), 64'd0);
        chk("zero_no_writes", 64'(wr_total), 64'd0);
        chk("zero_err", {63'd0, err}, 64'd0);

        // Bad header, then go is ignored
        do_reset();
        set_image(32'hC00, 32'd5, 32'd0, 32'd1, 5);
        wr_total = 0;
        pulse_go();
        wait_end(200);
        chk("bad_status", {61'd0, busy, start, err}, 64'b001);
        rd_before = rd_total;
        pulse_go();
        repeat (20) @(negedge sys_clk);
        chk("bad_hold", {61'd0, busy, start, err}, 64'b001);
        chk("bad_no_reads_after", 64'(rd_total), 64'(rd_before));
        chk("bad_no_writes", 64'(wr_total), 64'd0);

        // SRAM address wrap with random stalls
        do_reset();
        set_image(32'h3FFFFE, 32'd3, 32'd0, 32'd0, 3);
        push_exp(22'h3FFFFE, pay[0]);
        push_exp(22'h3FFFFF, pay[1]);
        push_exp(22'h000000, pay[2]);
        rnd = 1'b1;
        pulse_go();
        wait_end(1000);
        rnd = 1'b0;
        chk("wrap_words_done", 64'(words_done), 64'd3);
        chk("wrap_status", {61'd0, busy, start, err}, 64'b010);
        chk("wrap_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset during the third write, late ack ignored, then reload
        do_reset();
        set_image(32'hC00, 32'd5, 32'd0, 32'd0, 5);
        for (int i = 0; i < 5; i++) push_exp(22'hC00 + 22'(i), pay[i]);
        wr_idx = 0;
        hold_idx = 2;
        pulse_go();
        for (int i = 0; i < 500 && !(sr_req && words_done == 32'd2); i++) @(negedge sys_clk);
        chk("mid_third_write_pending", {63'd0, sr_req && words_done == 32'd2}, 64'd1);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("mid_rst_reqs", {62'd0, fl_req, sr_req}, 64'd0);
        chk("mid_rst_status", {61'd0, busy, start, err}, 64'd0);
        chk("mid_rst_counts", 64'({words_done, sr_wdata}), 64'd0);
        chk("mid_rst_addrs", 64'({fl_addr, sr_addr}), 64'd0);
        sys_rst = 1'b1;
        hold_idx = -1;
        late_ack = 1'b1;
        repeat (4) @(negedge sys_clk);
        chk("late_ack_ignored", {60'd0, fl_req, sr_req, busy, start}, 64'd0);
        chk("late_ack_words", 64'(words_done), 64'd0);
        exp_q.delete();
        for (int i = 0; i < 5; i++) push_exp(22'hC00 + 22'(i), pay[i]);
        wr_idx = 0;
        pulse_go();
        wait_end(500);
        chk("reload_words_done", 64'(words_done), 64'd5);
        chk("reload_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("reload_status", {61'd0, busy, start, err}, 64'b010);

        // go held high through the load and toggled during RD
        do_reset();
        set_image(32'hC00, 32'd5, 32'd0, 32'd0, 5);
        for (int i = 0; i < 5; i++) push_exp(22'hC00 + 22'(i), pay[i]);
        repeat (2) @(negedge sys_clk);
        start_rises = 0;
        @(negedge sys_clk) go = 1'b1;
        repeat (14) @(negedge sys_clk);
        go = 1'b0;
        @(negedge sys_clk) go = 1'b1;
        wait_end(500);
        repeat (30) @(negedge sys_clk);
        go = 1'b0;
        chk("held_start_rises", 64'(start_rises), 64'd1);
        chk("held_words_done", 64'(words_done), 64'd5);
        chk("held_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("held_flash_reads", 64'(rd_total), 64'd9);
        chk("held_status", {61'd0, busy, start, err}, 64'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
